// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: shared constants and state encoding for the instruction fetcher
package instruction_fetcher_pkg;
  localparam int unsigned LEN_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: owns the PC, issues single-outstanding word fetches and
// presents one registered instruction to decode under valid/ready.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned LEN = LEN_DEFAULT,
  parameter logic [LEN-1:0] RESET_PC = LEN'(RESET_PC_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy_in,
  output logic           mem_req_valid,
  output logic [LEN-1:0] mem_req_addr,
  input  logic           mem_req_ready,
  input  logic           mem_resp_valid,
  input  logic [LEN-1:0] mem_resp_data,
  output logic           inst_valid,
  output logic [LEN-1:0] instruction,
  output logic [LEN-1:0] inst_pc,
  input  logic           inst_ready,
  input  logic           redirect_valid,
  input  logic [LEN-1:0] redirect_pc
);
  fetch_state_e state_q, state_d;
  logic [LEN-1:0] pc_q, pc_d, instruction_q, instruction_d, inst_pc_q, inst_pc_d;
  logic inst_valid_q, inst_valid_d, drop_q, drop_d;
  logic redir, resp, load, fire;
  // A request is only issued when the output register will be free on return.
  assign mem_req_valid = rst_n & rdy_in & (state_q == FETCH_REQ) & ~redirect_valid
                       & (~inst_valid_q | inst_ready);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign instruction   = instruction_q;
  assign inst_pc       = inst_pc_q;
  always_comb begin
    redir         = rdy_in & redirect_valid;
    resp          = (state_q == FETCH_WAIT) & mem_resp_valid;
    load          = resp & ~drop_q & ~redir;
    fire          = mem_req_valid & mem_req_ready;
    state_d       = resp ? FETCH_REQ : fire ? FETCH_WAIT : state_q;
    drop_d        = resp ? 1'b0 : (redir & state_q == FETCH_WAIT) ? 1'b1 : drop_q;
    pc_d          = redir ? {redirect_pc[LEN-1:2], 2'b00} : load ? pc_q + LEN'(4) : pc_q;
    inst_valid_d  = redir ? 1'b0 : load ? 1'b1 : (rdy_in & inst_ready) ? 1'b0 : inst_valid_q;
    instruction_d = load ? mem_resp_data : instruction_q;
    inst_pc_d     = load ? pc_q : inst_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      instruction_q <= '0;
      inst_pc_q     <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
      drop_q        <= drop_d;
    end
  end
endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Producer side of the decoder's instruction input: owns the program counter, issues word fetches to instruction memory over a valid/ready request and a valid response channel, and presents one registered instruction (with its PC) to the decode stage under a valid/ready handshake. Sits between instruction memory and the decoder. Accepts a PC redirect from the branch-resolution stage, which the decoder flags via special_pc_flag/branch_flag. Single outstanding memory request; one-entry output register.

## Interface
- LEN, 32, instruction and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; low freezes the block (see Operation)
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  LEN  fetch address; always the current PC
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_resp_valid  in  1  fetched word valid; exactly one per accepted request, in a cycle strictly after acceptance
- mem_resp_data  in  LEN  fetched word
- inst_valid  out  1  instruction register holds a valid instruction
- instruction  out  LEN  instruction to the decoder
- inst_pc  out  LEN  address of instruction
- inst_ready  in  1  decoder consumes instruction this cycle
- redirect_valid  in  1  taken branch/jump; replace PC
- redirect_pc  in  LEN  new PC; bits [1:0] are ignored and treated as 0

## Operation
- State machine: REQ (request may be issued), WAIT (request outstanding).
- Reset values: state=REQ, pc=RESET_PC, inst_valid=0, instruction=0, inst_pc=0, drop=0. mem_req_valid=0 while rst_n low.
- mem_req_valid = rdy_in & (state==REQ) & !redirect_valid & (!inst_valid | inst_ready). A response therefore always finds the output register empty.
- REQ: on mem_req_valid & mem_req_ready → WAIT. pc is unchanged until the response arrives.
- WAIT: on mem_resp_valid:
  - drop=0: instruction<=data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^LEN, wraps at 0xFFFF_FFFC→0), → REQ.
  - drop=1: discard data, drop<=0, → REQ.
- Consume: inst_valid & inst_ready clears inst_valid unless a new response loads the register in the same cycle.
- Redirect (highest priority, any state): pc<={redirect_pc[LEN-1:2],2'b00}, inst_valid<=0 (flush). In WAIT with no response this cycle: drop<=1. In WAIT with a response this cycle: data discarded, → REQ, drop=0. No request is issued in a redirect cycle.
- A second redirect while drop=1 only updates pc; drop stays 1.
- rdy_in low: pc, inst_* and state hold. No request is issued. In WAIT, a response is still captured (memory does not stall).
- Reset mid-operation: all state clears immediately. A response from a pre-reset request that arrives after reset is ignored, because the state is REQ.

## Timing
- First request: combinational in the first clk after rst_n deasserts (rdy_in=1).
- Response in cycle M → inst_valid=1 from cycle M+1.
- Sustained throughput with 1-cycle memory and inst_ready=1: one instruction every 2 cycles.
- mem_req_valid depends combinationally on inst_ready, redirect_valid and rdy_in. All other outputs are registered.

## Structure
- The shared defines header holds RESET_PC default, the state encodings (FETCH_REQ=1'b0, FETCH_WAIT=1'b1) and the NOP constant 32'h0000_0013, used by the bench.
- No sub-module. The single-entry output register is inline; a future multi-entry queue becomes sub-module fetch_queue.

## Test plan
- Reset, RESET_PC=0, memory returns 0x00500093 one cycle after acceptance → req addr 0 cycle 0; inst_valid cycle 2 with instruction=0x00500093, inst_pc=0; next req addr 4.
- inst_ready=0 for 5 cycles with inst_valid=1 → mem_req_valid stays 0 and the instruction is held. inst_ready=1 → the request for the next PC is issued in that same cycle.
- Redirect to 0x100 while WAIT for addr 8 → the response for 8 is discarded, inst_valid never shows it, and the next req addr is 0x100.
- Redirect_pc=0x103 in the same cycle as a response → the response is discarded and the next req addr is 0x100.
- rdy_in=0 for 3 cycles in REQ → no request, pc held. In WAIT, the response is captured and inst_valid rises.
- pc=0xFFFF_FFFC fetch → next req addr 0x0000_0000. An assertion of rst_n mid-WAIT → all outputs return to reset values.
